// File: rtl/reaction_ctrl_if.sv
// Handshake bundle between the reaction-timer sequencer and its surrounding blocks.
// master drives the button/counter inputs, slave is the sequencer itself.
interface reaction_ctrl_if #(
    parameter int unsigned TIME_W = 14
);
    logic              start;
    logic              stop;
    logic              rand_done;
    logic              error_wait_done;
    logic              rand_wait;
    logic              error_wait;
    logic              led_go;
    logic [TIME_W-1:0] time_ms;
    logic [1:0]        disp_mode;

    modport master (
        output start, stop, rand_done, error_wait_done,
        input  rand_wait, error_wait, led_go, time_ms, disp_mode
    );

    modport slave (
        input  start, stop, rand_done, error_wait_done,
        output rand_wait, error_wait, led_go, time_ms, disp_mode
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: random wait, GO phase with millisecond timing, error and slow handling.
// All outputs are registered and decoded from the next state.
module reaction_ctrl #(
    parameter int unsigned MS_DIV = 100000,
    parameter int unsigned MAX_MS = 9999,
    parameter int unsigned TIME_W = 14
) (
    input logic            clk,
    input logic            reset,
    reaction_ctrl_if.slave bus_io
);
    localparam int unsigned PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_DIV - 1);
    localparam logic [TIME_W-1:0] TIME_MAX  = TIME_W'(MAX_MS);
    localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(MAX_MS - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StRandWait = 3'd1;
    localparam logic [2:0] StGo       = 3'd2;
    localparam logic [2:0] StDone     = 3'd3;
    localparam logic [2:0] StError    = 3'd4;
    localparam logic [2:0] StSlow     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              rand_wait_q, error_wait_q, led_go_q;
    logic [1:0]        disp_mode_q, disp_mode_d;
    logic              tick;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        time_d  = time_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StRandWait;
                    pre_d   = '0;
                    time_d  = '0;
                end
            end
            StRandWait: begin
                // An early press wins over a simultaneous delay expiry.
                if (bus_io.stop) begin
                    state_d = StError;
                end else if (bus_io.rand_done) begin
                    state_d = StGo;
                end
            end
            StGo: begin
                if (bus_io.stop) begin
                    state_d = StDone;
                end else if (tick) begin
                    pre_d = '0;
                    if (time_q == TIME_LAST) begin
                        time_d  = TIME_MAX;
                        state_d = StSlow;
                    end else begin
                        time_d = time_q + TIME_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            StDone, StSlow: begin
                if (bus_io.start) begin
                    state_d = StRandWait;
                    pre_d   = '0;
                    time_d  = '0;
                end
            end
            StError: begin
                if (bus_io.error_wait_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        disp_mode_d = 2'd0;
        case (state_d)
            StGo, StDone: disp_mode_d = 2'd1;
            StError:      disp_mode_d = 2'd2;
            StSlow:       disp_mode_d = 2'd3;
            default:      disp_mode_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pre_q        <= '0;
            time_q       <= '0;
            rand_wait_q  <= 1'b0;
            error_wait_q <= 1'b0;
            led_go_q     <= 1'b0;
            disp_mode_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            time_q       <= time_d;
            rand_wait_q  <= (state_d == StRandWait);
            error_wait_q <= (state_d == StError);
            led_go_q     <= (state_d == StGo);
            disp_mode_q  <= disp_mode_d;
        end
    end

    assign bus_io.rand_wait  = rand_wait_q;
    assign bus_io.error_wait = error_wait_q;
    assign bus_io.led_go     = led_go_q;
    assign bus_io.time_ms    = time_q;
    assign bus_io.disp_mode  = disp_mode_q;
endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: directed scenarios followed by random stimulus,
// expected outputs come from a phase/elapsed-cycle model of the timer.
module tb_reaction_ctrl;
    localparam int unsigned MS_DIV = 4;
    localparam int unsigned MAX_MS = 5;
    localparam int unsigned TW     = 14;

    typedef enum int {MIdle, MWait, MGo, MDone, MErr, MSlow} phase_t;

    typedef struct packed {
        logic          rw;
        logic          ew;
        logic          go;
        logic [TW-1:0] t;
        logic [1:0]    dm;
    } exp_t;

    logic clk;
    logic reset;
    reaction_ctrl_if #(.TIME_W(TW)) bus_if ();

    reaction_ctrl #(
        .MS_DIV(MS_DIV),
        .MAX_MS(MAX_MS),
        .TIME_W(TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    exp_t   exp_q[$];
    phase_t phase = MIdle;
    int     go_n  = 0;
    int     t_ms  = 0;

    function automatic exp_t expected();
        exp_t e;
        e.rw = (phase == MWait);
        e.ew = (phase == MErr);
        e.go = (phase == MGo);
        e.t  = TW'(t_ms);
        case (phase)
            MGo, MDone: e.dm = 2'd1;
            MErr:       e.dm = 2'd2;
            MSlow:      e.dm = 2'd3;
            default:    e.dm = 2'd0;
        endcase
        return e;
    endfunction

    // Elapsed time is simply completed GO cycles divided by the tick period.
    task automatic model_step(input bit s, input bit p, input bit rd, input bit ew, input bit rs);
        if (rs) begin
            phase = MIdle;
            go_n  = 0;
            t_ms  = 0;
        end else begin
            case (phase)
                MIdle, MDone, MSlow: if (s) begin
                    phase = MWait;
                    go_n  = 0;
                    t_ms  = 0;
                end
                MWait: if (p) phase = MErr; else if (rd) phase = MGo;
                MGo: if (p) begin
                    phase = MDone;
                end else begin
                    go_n = go_n + 1;
                    t_ms = go_n / MS_DIV;
                    if (t_ms >= MAX_MS) begin
                        t_ms  = MAX_MS;
                        phase = MSlow;
                    end
                end
                MErr: if (ew) phase = MIdle;
                default: phase = MIdle;
            endcase
        end
    endtask

    task automatic step(input bit s, input bit p, input bit rd, input bit ew, input bit rs);
        @(negedge clk);
        bus_if.start           = s;
        bus_if.stop            = p;
        bus_if.rand_done       = rd;
        bus_if.error_wait_done = ew;
        reset                  = rs;
        model_step(s, p, rd, ew, rs);
        exp_q.push_back(expected());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares one expected entry per cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rand_wait", int'(bus_if.rand_wait), int'(e.rw));
                check("error_wait", int'(bus_if.error_wait), int'(e.ew));
                check("led_go", int'(bus_if.led_go), int'(e.go));
                check("time_ms", int'(bus_if.time_ms), int'(e.t));
                check("disp_mode", int'(bus_if.disp_mode), int'(e.dm));
            end
        end
    end

    initial begin
        int wait_cycles;
        reset                  = 1'b1;
        bus_if.start           = 1'b0;
        bus_if.stop            = 1'b0;
        bus_if.rand_done       = 1'b0;
        bus_if.error_wait_done = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of GO with time_ms at 2.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(9);
        @(negedge clk);
        #2;
        check("pre_reset_time", int'(bus_if.time_ms), 2);
        reset = 1'b1;
        #1;
        check("async_rst_led_go", int'(bus_if.led_go), 0);
        check("async_rst_time", int'(bus_if.time_ms), 0);
        check("async_rst_disp", int'(bus_if.disp_mode), 0);
        check("async_rst_waits", int'(bus_if.rand_wait) + int'(bus_if.error_wait), 0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Normal run: stop after 13 GO cycles gives 3 ms.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(13);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Early press colliding with rand_done, then a long error display.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(i % 3 == 0, i % 4 == 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Tick and stop on the same edge: the tick is dropped.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Restart from DONE, then run into the slow limit and restart from SLOW.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(22);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 299) == 0);
        end
        idle(2);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
